// File: rtl/accu_frame_gen.sv
// -----------------------------------------------------------------------------
// accu_frame_gen
// AXI-Stream frame source and result checker for the accumulator datapath.
// On an accepted start it sends one header word carrying the payload length N,
// then N payload words (seed, seed+step, seed+2*step, ...), with tlast on the
// final payload beat. It then waits for a single response word and compares it
// against the locally accumulated sum of the transmitted payload.
//
// Ports
//   sys_clk, sys_rst          clock / synchronous active-high reset
//   start, frame_len,
//   seed, step_val            frame request and its parameters (sampled in IDLE)
//   busy, done, pass,
//   err_timeout, err_len      status
//   expected_sum, rx_sum      locally accumulated sum / received sum
//   m_axis_*                  outgoing frame stream (header + payload)
//   s_axis_*                  incoming single-word response stream
// -----------------------------------------------------------------------------
module accu_frame_gen #(
    parameter int RESP_TIMEOUT = 1024,
    parameter int LEN_W        = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [63:0]      seed,
    input  logic [63:0]      step_val,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_timeout,
    output logic             err_len,
    output logic [63:0]      expected_sum,
    output logic [63:0]      rx_sum,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tlast
);

    // Counter only needs to reach RESP_TIMEOUT-1; the timeout fires on the
    // edge at which it would reach RESP_TIMEOUT.
    localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [63:0]       r_cur;
    logic [63:0]       r_step;
    logic [63:0]       r_exp_sum;
    logic [63:0]       r_rx_sum;
    logic              r_pass;
    logic              r_err_to;
    logic              r_err_len;
    logic [CNT_W-1:0]  r_tcnt;

    logic              w_m_valid;
    logic              w_m_beat;
    logic              w_s_beat;
    logic              w_last;
    logic              w_timeout;
    logic              w_start_ok;

    // All stream controls decode straight from the state register, so tvalid
    // never depends on tready and everything is zero in IDLE / after reset.
    assign w_m_valid  = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_m_beat   = w_m_valid && m_axis_tready;
    assign w_s_beat   = (r_state == S_WAIT) && s_axis_tvalid;
    assign w_last     = (r_idx == (r_len - 1'b1));
    assign w_timeout  = (RESP_TIMEOUT != 0) && (r_tcnt == TO_LAST);
    assign w_start_ok = start && (frame_len != '0);

    assign m_axis_tvalid = w_m_valid;
    assign m_axis_tkeep  = w_m_valid ? 8'hFF : 8'h00;
    assign m_axis_tlast  = (r_state == S_DATA) && w_last;
    assign m_axis_tdata  = (r_state == S_HDR)  ? {{(64-LEN_W){1'b0}}, r_len} :
                           (r_state == S_DATA) ? r_cur : 64'd0;
    assign s_axis_tready = (r_state == S_WAIT);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;
    assign err_timeout   = r_err_to;
    assign err_len       = r_err_len;
    assign expected_sum  = r_exp_sum;
    assign rx_sum        = r_rx_sum;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_next = S_HDR;
            S_HDR:  if (w_m_beat) w_state_next = S_DATA;
            S_DATA: if (w_m_beat && w_last) w_state_next = S_WAIT;
            S_WAIT: if (w_s_beat || w_timeout) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_len     <= '0;
            r_idx     <= '0;
            r_cur     <= '0;
            r_step    <= '0;
            r_exp_sum <= '0;
            r_rx_sum  <= '0;
            r_pass    <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_len <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_len     <= frame_len;
                        r_cur     <= seed;
                        r_step    <= step_val;
                        r_idx     <= '0;
                        r_exp_sum <= '0;
                        r_rx_sum  <= '0;
                        r_pass    <= 1'b0;
                        r_err_to  <= 1'b0;
                        r_tcnt    <= '0;
                    end else if (start) begin
                        r_err_len <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_m_beat) begin
                        r_exp_sum <= r_exp_sum + r_cur;
                        r_cur     <= r_cur + r_step;
                        r_idx     <= r_idx + 1'b1;
                    end
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    // A response on the timeout cycle takes priority.
                    if (w_s_beat) begin
                        r_rx_sum <= s_axis_tdata;
                        r_pass   <= (s_axis_tdata == r_exp_sum) &&
                                    (s_axis_tkeep == 8'hFF) && s_axis_tlast;
                    end else if (w_timeout) begin
                        r_err_to <= 1'b1;
                        r_pass   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accu_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_accu_frame_gen
// Directed + randomized bench for accu_frame_gen. Payload words and the
// expected sum come from seed + i*step arithmetic in the bench.
// -----------------------------------------------------------------------------
module tb_accu_frame_gen;

    localparam int TO    = 16;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             sys_rst;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic [63:0]      seed;
    logic [63:0]      step_val;
    logic             busy, done, pass, err_timeout, err_len;
    logic [63:0]      expected_sum, rx_sum;
    logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [63:0]      m_axis_tdata;
    logic [7:0]       m_axis_tkeep;
    logic             s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [63:0]      s_axis_tdata;
    logic [7:0]       s_axis_tkeep;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    accu_frame_gen #(.RESP_TIMEOUT(TO), .LEN_W(LEN_W)) dut (
        .sys_clk       (clk),
        .sys_rst       (sys_rst),
        .start         (start),
        .frame_len     (frame_len),
        .seed          (seed),
        .step_val      (step_val),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_timeout   (err_timeout),
        .err_len       (err_len),
        .expected_sum  (expected_sum),
        .rx_sum        (rx_sum),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 0);
        chk({tag, "_tdata"},  m_axis_tdata, 0);
        chk({tag, "_tkeep"},  m_axis_tkeep, 0);
        chk({tag, "_tlast"},  m_axis_tlast, 0);
        chk({tag, "_stready"}, s_axis_tready, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_pass"},   pass, 0);
        chk({tag, "_errto"},  err_timeout, 0);
        chk({tag, "_errlen"}, err_len, 0);
        chk({tag, "_expsum"}, expected_sum, 0);
        chk({tag, "_rxsum"},  rx_sum, 0);
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] len, input logic [63:0] sd,
                               input logic [63:0] st);
        start = 1'b1; frame_len = len; seed = sd; step_val = st;
        tick;
        start = 1'b0; frame_len = '0; seed = '0; step_val = '0;
        chk("start_tvalid", m_axis_tvalid, 1);
        chk("start_busy", busy, 1);
        chk("start_stready", s_axis_tready, 0);
    endtask

    // mode 0: tready always 1, 1: alternating 1/0, 2: random
    task automatic send_payload(input int len, input logic [63:0] sd, input logic [63:0] st,
                                input int mode, output logic [63:0] sum);
        int k;
        int guard;
        logic [63:0] w;
        sum = 0; k = 0; guard = 0;
        while (k <= len && guard < 20 * len + 50) begin
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (guard % 2 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            w = (k == 0) ? 64'(len) : sd + 64'(k - 1) * st;
            chk("beat_tvalid", m_axis_tvalid, 1);
            chk("beat_tkeep", m_axis_tkeep, 8'hFF);
            chk("beat_tdata", m_axis_tdata, w);
            chk("beat_tlast", m_axis_tlast, (k == len));
            if (m_axis_tready) begin
                if (k > 0) sum = sum + w;
                k++;
            end
            tick;
            guard++;
        end
        m_axis_tready = 1'b0;
        chk("beat_count", k, len + 1);
        chk("post_tvalid", m_axis_tvalid, 0);
        chk("wait_stready", s_axis_tready, 1);
        chk("expected_sum", expected_sum, sum);
    endtask

    task automatic respond(input int delay, input logic [63:0] data, input logic [7:0] keep,
                           input logic last, input logic [63:0] sum);
        logic exp_pass;
        for (int i = 0; i < delay; i++) begin
            chk("wait_stready_hold", s_axis_tready, 1);
            chk("wait_no_done", done, 0);
            tick;
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = data; s_axis_tkeep = keep; s_axis_tlast = last;
        tick;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        exp_pass = (data == sum) && (keep == 8'hFF) && last;
        chk("resp_done", done, 1);
        chk("resp_pass", pass, exp_pass);
        chk("resp_rxsum", rx_sum, data);
        chk("resp_errto", err_timeout, 0);
        chk("resp_stready", s_axis_tready, 0);
        $display("frame: sum=0x%0h resp=0x%0h keep=%h last=%0b delay=%0d pass=%0b",
                 sum, data, keep, last, delay, pass);
        tick;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_pass_held", pass, exp_pass);
    endtask

    task automatic full_frame(input int len, input logic [63:0] sd, input logic [63:0] st,
                              input int mode, input int delay, input int corrupt);
        logic [63:0] sum;
        logic [63:0] d;
        logic [7:0]  kp;
        logic        lst;
        start_frame(LEN_W'(len), sd, st);
        send_payload(len, sd, st, mode, sum);
        d = sum; kp = 8'hFF; lst = 1'b1;
        case (corrupt)
            1: d  = sum + 64'd1;
            2: kp = 8'h0F;
            3: lst = 1'b0;
            default: ;
        endcase
        respond(delay, d, kp, lst, sum);
    endtask

    initial begin
        logic [63:0] sum;
        int cnt;
        sys_rst = 1'b1; start = 1'b0; frame_len = '0; seed = '0; step_val = '0;
        m_axis_tready = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        tick; tick;
        chk_all_zero("reset");
        sys_rst = 1'b0;
        tick;

        // Basic frame, no stalls, correct response of 10
        start_frame(4, 64'd1, 64'd1);
        send_payload(4, 64'd1, 64'd1, 0, sum);
        chk("basic_sum10", sum, 64'd10);
        respond(0, 64'd10, 8'hFF, 1'b1, sum);

        // Alternating backpressure
        full_frame(4, 64'd1, 64'd1, 1, 2, 0);
        // Bad data, bad keep, missing tlast
        full_frame(4, 64'd1, 64'd1, 0, 0, 1);
        full_frame(4, 64'd1, 64'd1, 0, 1, 2);
        full_frame(4, 64'd1, 64'd1, 0, 3, 3);
        // Wraparound: 2 x 0x8000... = 0 mod 2^64
        full_frame(2, 64'h8000_0000_0000_0000, 64'd0, 0, 0, 0);

        // Timeout with no response
        start_frame(3, 64'd5, 64'd7);
        send_payload(3, 64'd5, 64'd7, 0, sum);
        cnt = 0;
        while (!done && cnt < 100) begin
            tick;
            cnt++;
        end
        chk("timeout_cycles", cnt, TO);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_pass", pass, 0);
        $display("frame: timeout after %0d cycles err_timeout=%0b", cnt, err_timeout);
        tick;
        chk("timeout_done_clear", done, 0);
        chk("timeout_err_held", err_timeout, 1);

        // Response exactly on the timeout cycle wins
        full_frame(3, 64'd5, 64'd7, 0, TO - 1, 0);

        // Zero-length start
        start = 1'b1; frame_len = '0;
        tick;
        start = 1'b0;
        chk("errlen_pulse", err_len, 1);
        chk("errlen_tvalid", m_axis_tvalid, 0);
        chk("errlen_busy", busy, 0);
        tick;
        chk("errlen_clear", err_len, 0);
        chk("errlen_idle_tvalid", m_axis_tvalid, 0);
        $display("frame: zero-length start rejected");

        // Reset after the second payload beat
        start_frame(4, 64'd1, 64'd1);
        m_axis_tready = 1'b1;
        tick; tick; tick;
        m_axis_tready = 1'b0;
        sys_rst = 1'b1;
        tick;
        sys_rst = 1'b0;
        chk_all_zero("midreset");
        $display("frame: reset mid-frame");
        tick;
        full_frame(4, 64'd1, 64'd1, 0, 0, 0);

        // Randomized frames
        for (int n = 0; n < 12; n++) begin
            full_frame($urandom_range(1, 9), {$urandom, $urandom}, {$urandom, $urandom},
                       2, $urandom_range(0, TO - 1), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
